// File: rtl/plab4_net_router_input_terminal_ctrl_tdm_pkg.sv
// ----------------------------------------------------------------------------
// plab4_net_router_input_terminal_ctrl_tdm_pkg
//
// Shared definitions for the ring-router terminal input control and its
// helpers: greedy route codes, one-hot request constants for the three-way
// output arbitration, and the input-control FSM state encoding.
// ----------------------------------------------------------------------------
package plab4_net_router_input_terminal_ctrl_tdm_pkg;

    // Greedy route decision for the head packet
    typedef enum logic [1:0] {
        ROUTE_PREV = 2'd0,
        ROUTE_TERM = 2'd1,
        ROUTE_NEXT = 2'd2
    } route_e;

    // One-hot request/grant encoding: [0] prev, [1] terminal, [2] next
    localparam logic [2:0] REQ_NONE = 3'b000;
    localparam logic [2:0] REQ_PREV = 3'b001;
    localparam logic [2:0] REQ_TERM = 3'b010;
    localparam logic [2:0] REQ_NEXT = 3'b100;

    // Input-control FSM states
    typedef enum logic {
        STATE_IDLE = 1'b0,
        STATE_HOLD = 1'b1
    } state_e;

    // Map a route code onto its one-hot request vector
    function automatic logic [2:0] route_to_req(input route_e route);
        logic [2:0] req;
        case (route)
            ROUTE_PREV: req = REQ_PREV;
            ROUTE_TERM: req = REQ_TERM;
            ROUTE_NEXT: req = REQ_NEXT;
            default:    req = REQ_NONE;
        endcase
        return req;
    endfunction

endpackage

// File: rtl/plab4_net_route_compute_greedy.sv
// ----------------------------------------------------------------------------
// plab4_net_route_compute_greedy
//
// Greedy ring route computation: a packet addressed to this router goes to
// the terminal; otherwise it takes the direction with fewer hops. When both
// directions are equally long the packet goes the prev way.
//
// Ports:
//   dest   in   destination router index of the head packet
//   route  out  ROUTE_PREV / ROUTE_TERM / ROUTE_NEXT
// ----------------------------------------------------------------------------
module plab4_net_route_compute_greedy
    import plab4_net_router_input_terminal_ctrl_tdm_pkg::*;
#(
    parameter int p_router_id   = 0,
    parameter int p_num_routers = 8,
    localparam int c_dest_nbits = $clog2(p_num_routers)
) (
    input  logic [c_dest_nbits-1:0] dest,
    output route_e                  route
);

    int dest_int;
    int forw_hops;
    int backw_hops;

    always_comb begin
        dest_int = int'(dest);
        // Hops travelling in the next direction, modulo the ring size
        if (dest_int >= p_router_id) begin
            forw_hops = dest_int - p_router_id;
        end else begin
            forw_hops = dest_int + p_num_routers - p_router_id;
        end
        backw_hops = p_num_routers - forw_hops;

        if (forw_hops == 0) begin
            route = ROUTE_TERM;
        end else if (forw_hops < backw_hops) begin
            route = ROUTE_NEXT;
        end else begin
            route = ROUTE_PREV;
        end
    end

endmodule

// File: rtl/plab4_net_tdm_slot_counter.sv
// ----------------------------------------------------------------------------
// plab4_net_tdm_slot_counter
//
// Time-division schedule shared by all controllers of a router. Each domain
// owns p_slot_len consecutive cycles in round-robin order; the last p_guard
// cycles of every slot are closed to new injections. The schedule runs
// regardless of traffic so that one domain's activity can never shift
// another domain's timing.
//
// Ports:
//   clk         in   clock
//   reset       in   asynchronous active-high reset
//   cycle_cnt   out  position inside the current slot (0..p_slot_len-1)
//   cur_domain  out  domain owning the current slot
//   slot_start  out  high on the first cycle of every slot
//   slot_open   out  high while new injections are permitted
// ----------------------------------------------------------------------------
module plab4_net_tdm_slot_counter #(
    parameter int p_num_domains = 2,
    parameter int p_slot_len    = 4,
    parameter int p_guard       = 1,
    localparam int c_dom_nbits  = (p_num_domains > 1) ? $clog2(p_num_domains) : 1,
    localparam int c_cnt_nbits  = $clog2(p_slot_len)
) (
    input  logic                   clk,
    input  logic                   reset,
    output logic [c_cnt_nbits-1:0] cycle_cnt,
    output logic [c_dom_nbits-1:0] cur_domain,
    output logic                   slot_start,
    output logic                   slot_open
);

    localparam logic [c_cnt_nbits-1:0] LAST_CYCLE = c_cnt_nbits'(p_slot_len - 1);
    localparam logic [c_cnt_nbits-1:0] LAST_OPEN  = c_cnt_nbits'(p_slot_len - p_guard - 1);
    localparam logic [c_dom_nbits-1:0] LAST_DOM   = c_dom_nbits'(p_num_domains - 1);

    logic [c_cnt_nbits-1:0] cycle_cnt_q, cycle_cnt_d;
    logic [c_dom_nbits-1:0] domain_q, domain_d;

    always_comb begin
        cycle_cnt_d = cycle_cnt_q + 1'b1;
        domain_d    = domain_q;
        if (cycle_cnt_q == LAST_CYCLE) begin
            cycle_cnt_d = '0;
            domain_d    = (domain_q == LAST_DOM) ? '0 : domain_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cycle_cnt_q <= '0;
            domain_q    <= '0;
        end else begin
            cycle_cnt_q <= cycle_cnt_d;
            domain_q    <= domain_d;
        end
    end

    assign cycle_cnt  = cycle_cnt_q;
    assign cur_domain = domain_q;
    // Counter is held at zero during reset, so slot_start reads high then too
    assign slot_start = (cycle_cnt_q == '0);
    // Comparing against the last open cycle keeps the constant in range even
    // when there is no guard band
    assign slot_open  = (cycle_cnt_q <= LAST_OPEN);

endmodule

// File: rtl/plab4_net_router_input_terminal_ctrl_tdm.sv
// ----------------------------------------------------------------------------
// plab4_net_router_input_terminal_ctrl_tdm
//
// Terminal input control of a ring router with time-division protection.
// The head packet may request an output only inside its own domain's slot
// and outside that slot's guard band. A request that is not granted is held
// (HOLD) with its route latched so the arbiters see a stable request until it
// is granted or withdrawn.
//
// Ports:
//   clk, reset      clock, asynchronous active-high reset
//   dest            destination of head packet
//   in_domain       domain tag of head packet
//   in_val, in_rdy  head valid / consumed this cycle
//   num_free_west   credits on the next-direction output
//   num_free_east   credits on the prev-direction output
//   reqs, grants    one-hot request to / grant from output arbiters
//   cur_domain      domain owning the current slot
//   slot_start      first cycle of every slot
// ----------------------------------------------------------------------------
module plab4_net_router_input_terminal_ctrl_tdm
    import plab4_net_router_input_terminal_ctrl_tdm_pkg::*;
#(
    parameter int p_router_id      = 0,
    parameter int p_num_routers    = 8,
    parameter int p_num_free_nbits = 2,
    parameter int p_num_domains    = 2,
    parameter int p_slot_len       = 4,
    parameter int p_guard          = 1,
    parameter int p_min_free       = 2,
    localparam int c_dest_nbits    = $clog2(p_num_routers),
    localparam int c_dom_nbits     = (p_num_domains > 1) ? $clog2(p_num_domains) : 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [c_dest_nbits-1:0]     dest,
    input  logic [c_dom_nbits-1:0]      in_domain,
    input  logic                        in_val,
    output logic                        in_rdy,
    input  logic [p_num_free_nbits-1:0] num_free_west,
    input  logic [p_num_free_nbits-1:0] num_free_east,
    output logic [2:0]                  reqs,
    input  logic [2:0]                  grants,
    output logic [c_dom_nbits-1:0]      cur_domain,
    output logic                        slot_start
);

    localparam int c_cnt_nbits = $clog2(p_slot_len);
    // One extra bit so a threshold equal to the counter range still fits
    localparam logic [p_num_free_nbits:0] MIN_FREE = (p_num_free_nbits + 1)'(p_min_free);

    logic [c_cnt_nbits-1:0] cycle_cnt;
    logic                   slot_open;
    route_e                 route;
    logic [2:0]             route_oh;
    logic [2:0]             credit_mask;
    logic                   active;
    logic [2:0]             reqs_c;

    state_e     state_q, state_d;
    logic [2:0] hroute_q, hroute_d;

    plab4_net_tdm_slot_counter #(
        .p_num_domains (p_num_domains),
        .p_slot_len    (p_slot_len),
        .p_guard       (p_guard)
    ) u_slot (
        .clk        (clk),
        .reset      (reset),
        .cycle_cnt  (cycle_cnt),
        .cur_domain (cur_domain),
        .slot_start (slot_start),
        .slot_open  (slot_open)
    );

    plab4_net_route_compute_greedy #(
        .p_router_id   (p_router_id),
        .p_num_routers (p_num_routers)
    ) u_route (
        .dest  (dest),
        .route (route)
    );

    assign route_oh = route_to_req(route);

    // Terminal output is never credit-gated
    assign credit_mask = { ({1'b0, num_free_west} >= MIN_FREE),
                           1'b1,
                           ({1'b0, num_free_east} >= MIN_FREE) };

    // cur_domain never exceeds p_num_domains-1, so an out-of-range tag can
    // never match and is never eligible
    assign active = in_val && (in_domain == cur_domain) && slot_open;

    always_comb begin
        state_d  = state_q;
        hroute_d = hroute_q;
        reqs_c   = REQ_NONE;
        case (state_q)
            STATE_IDLE: begin
                if (active) begin
                    reqs_c = route_oh & credit_mask;
                end
                // Credit-blocked requests stay in IDLE and re-route next cycle
                if ((reqs_c != REQ_NONE) && ((reqs_c & grants) == REQ_NONE)) begin
                    state_d  = STATE_HOLD;
                    hroute_d = route_oh;
                end
            end
            STATE_HOLD: begin
                if (active) begin
                    reqs_c = hroute_q & credit_mask;
                end
                // Leave on consume, guard start, valid drop or domain change
                if (!active || ((reqs_c & grants) != REQ_NONE)) begin
                    state_d  = STATE_IDLE;
                    hroute_d = REQ_NONE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= STATE_IDLE;
            hroute_q <= REQ_NONE;
        end else begin
            state_q  <= state_d;
            hroute_q <= hroute_d;
        end
    end

    // The state register is already cleared during reset, but an eligible head
    // would still request combinationally; mask so nothing leaks out then
    assign reqs   = reset ? REQ_NONE : reqs_c;
    assign in_rdy = |(reqs & grants);

endmodule

// File: tb/tb_plab4_net_router_input_terminal_ctrl_tdm.sv
// ----------------------------------------------------------------------------
// Directed bench for plab4_net_router_input_terminal_ctrl_tdm.
// Main instance: router 2 of 8, 2 domains, slot 4, guard 1, min_free 2.
// A second instance with 3 domains exercises an out-of-range domain tag.
// Inputs change on the falling edge; outputs are checked 1 time unit later.
// ----------------------------------------------------------------------------
module tb_plab4_net_router_input_terminal_ctrl_tdm;

    logic       clk;
    logic       reset;
    logic [2:0] dest;
    logic [0:0] in_domain;
    logic       in_val;
    logic       in_rdy;
    logic [1:0] num_free_west;
    logic [1:0] num_free_east;
    logic [2:0] reqs;
    logic [2:0] grants;
    logic [0:0] cur_domain;
    logic       slot_start;

    logic [1:0] in_domain3;
    logic       in_val3;
    logic       in_rdy3;
    logic [2:0] reqs3;
    logic [1:0] cur_domain3;
    logic       slot_start3;

    int n_cmp = 0;
    int n_err = 0;

    plab4_net_router_input_terminal_ctrl_tdm #(
        .p_router_id(2), .p_num_routers(8), .p_num_free_nbits(2),
        .p_num_domains(2), .p_slot_len(4), .p_guard(1), .p_min_free(2)
    ) dut (
        .clk(clk), .reset(reset), .dest(dest), .in_domain(in_domain),
        .in_val(in_val), .in_rdy(in_rdy), .num_free_west(num_free_west),
        .num_free_east(num_free_east), .reqs(reqs), .grants(grants),
        .cur_domain(cur_domain), .slot_start(slot_start)
    );

    plab4_net_router_input_terminal_ctrl_tdm #(
        .p_router_id(2), .p_num_routers(8), .p_num_free_nbits(2),
        .p_num_domains(3), .p_slot_len(4), .p_guard(1), .p_min_free(2)
    ) dut3 (
        .clk(clk), .reset(reset), .dest(dest), .in_domain(in_domain3),
        .in_val(in_val3), .in_rdy(in_rdy3), .num_free_west(num_free_west),
        .num_free_east(num_free_east), .reqs(reqs3), .grants(grants),
        .cur_domain(cur_domain3), .slot_start(slot_start3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, required finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    task automatic drive(input logic [2:0] d, input logic [0:0] dom, input logic v,
                         input logic [1:0] fw, input logic [1:0] fe, input logic [2:0] g);
        dest          = d;
        in_domain     = dom;
        in_val        = v;
        num_free_west = fw;
        num_free_east = fe;
        grants        = g;
    endtask

    // Leaves the bench at the start of cycle 0 (just after deassertion)
    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        reset      = 1'b1;
        in_domain3 = 2'd0;
        in_val3    = 1'b0;
        drive(3'd2, 1'd0, 1'b0, 2'd0, 2'd0, 3'b000);

        // Reset state: an otherwise eligible TERM packet with a grant
        @(negedge clk);
        drive(3'd2, 1'd0, 1'b1, 2'd3, 2'd3, 3'b010);
        @(posedge clk);
        #1;
        check("rst_reqs", 32'(reqs), 32'h0);
        check("rst_in_rdy", 32'(in_rdy), 32'h0);
        check("rst_cur_domain", 32'(cur_domain), 32'h0);
        check("rst_slot_start", 32'(slot_start), 32'h1);

        // T1: next route granted in cycle 0
        drive(3'd0, 1'd0, 1'b0, 2'd0, 2'd0, 3'b000);
        do_reset();
        drive(3'd3, 1'd0, 1'b1, 2'd3, 2'd0, 3'b100);
        #1;
        check("t1_reqs", 32'(reqs), 32'h4);
        check("t1_in_rdy", 32'(in_rdy), 32'h1);

        // T2: domain 1 waits for its slot, then prev is granted at cycle 4
        drive(3'd0, 1'd0, 1'b0, 2'd0, 2'd0, 3'b000);
        do_reset();
        for (int c = 0; c <= 4; c++) begin
            drive(3'd1, 1'd1, 1'b1, 2'd0, 2'd3, 3'b001);
            #1;
            check($sformatf("t2_reqs_c%0d", c), 32'(reqs), (c < 4) ? 32'h0 : 32'h1);
            check($sformatf("t2_in_rdy_c%0d", c), 32'(in_rdy), (c < 4) ? 32'h0 : 32'h1);
            @(negedge clk);
        end

        // T3: credit gate on the next output, threshold crossed at cycle 1
        drive(3'd0, 1'd0, 1'b0, 2'd0, 2'd0, 3'b000);
        do_reset();
        drive(3'd3, 1'd0, 1'b1, 2'd1, 2'd3, 3'b000);
        #1;
        check("t3_reqs_c0_low_credit", 32'(reqs), 32'h0);
        @(negedge clk);
        drive(3'd3, 1'd0, 1'b1, 2'd2, 2'd3, 3'b000);
        #1;
        check("t3_reqs_c1_credit_ok", 32'(reqs), 32'h4);

        // T4: terminal request held, stable against dest change, withdrawn
        // at guard, re-requested in domain 0's next slot
        drive(3'd0, 1'd0, 1'b0, 2'd0, 2'd0, 3'b000);
        do_reset();
        for (int c = 0; c <= 8; c++) begin
            if (c == 0) begin
                drive(3'd2, 1'd0, 1'b1, 2'd3, 2'd3, 3'b100);   // mismatched grant
            end else if (c <= 2) begin
                drive(3'd5, 1'd0, 1'b1, 2'd3, 2'd3, 3'b000);   // would route next
            end else if (c < 8) begin
                drive(3'd2, 1'd0, 1'b1, 2'd3, 2'd3, 3'b000);
            end else begin
                drive(3'd2, 1'd0, 1'b1, 2'd3, 2'd3, 3'b010);
            end
            #1;
            check($sformatf("t4_reqs_c%0d", c), 32'(reqs), (c <= 2 || c == 8) ? 32'h2 : 32'h0);
            if (c == 0 || c == 8) begin
                check($sformatf("t4_in_rdy_c%0d", c), 32'(in_rdy), (c == 8) ? 32'h1 : 32'h0);
            end
            if (c < 8) @(negedge clk);
        end

        // T5: schedule and out-of-range domain on the 3-domain instance
        drive(3'd2, 1'd0, 1'b0, 2'd3, 2'd3, 3'b010);
        do_reset();
        in_val3    = 1'b1;
        in_domain3 = 2'd3;
        for (int c = 0; c < 16; c++) begin
            #1;
            check($sformatf("t5_slot_start_c%0d", c), 32'(slot_start), (c % 4 == 0) ? 32'h1 : 32'h0);
            check($sformatf("t5_cur_domain_c%0d", c), 32'(cur_domain), 32'((c / 4) % 2));
            check($sformatf("t5_cur_domain3_c%0d", c), 32'(cur_domain3), 32'((c / 4) % 3));
            check($sformatf("t5_reqs3_c%0d", c), 32'(reqs3), 32'h0);
            check($sformatf("t5_in_rdy3_c%0d", c), 32'(in_rdy3), 32'h0);
            @(negedge clk);
        end
        in_val3    = 1'b0;
        in_domain3 = 2'd0;

        // T6: reset asserted while in HOLD drops the request immediately
        drive(3'd0, 1'd0, 1'b0, 2'd0, 2'd0, 3'b000);
        do_reset();
        drive(3'd2, 1'd0, 1'b1, 2'd3, 2'd3, 3'b000);
        #1;
        check("t6_reqs_c0", 32'(reqs), 32'h2);
        @(negedge clk);
        #1;
        check("t6_reqs_c1_hold", 32'(reqs), 32'h2);
        reset  = 1'b1;
        grants = 3'b010;
        #1;
        check("t6_reqs_in_reset", 32'(reqs), 32'h0);
        check("t6_in_rdy_in_reset", 32'(in_rdy), 32'h0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("t6_slot_start_after", 32'(slot_start), 32'h1);
        check("t6_cur_domain_after", 32'(cur_domain), 32'h0);
        check("t6_reqs_after", 32'(reqs), 32'h2);
        check("t6_in_rdy_after", 32'(in_rdy), 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
